// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR ownership and RAM strobe sequencing for the Mini SRC
// datapath. The RAM has one cycle of registered read latency. The optional
// out-of-range fault check is compiled in with `define MEM_FAULT_EN.
module mem_interface #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 512
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mem_read_req,
    input  logic              mem_write_req,
    output logic [DATA_W-1:0] mdr_out_data,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_fault,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              out_of_range;

    // Register loads: bus loads only in IDLE/DONE, RAM capture in RD_CAPTURE.
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        case (state_q)
            IDLE, DONE: begin
                if (mar_in) mar_d = bus_in[ADDR_W-1:0];
                if (mdr_in) mdr_d = bus_in;
            end
            RD_CAPTURE: mdr_d = ram_rdata;
            default: ;
        endcase
    end

    // Next-state logic; requests in IDLE see this cycle's MAR load via mar_d.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_write_req || mem_read_req) begin
                    if (out_of_range)       state_d = DONE;
                    else if (mem_write_req) state_d = WR_ISSUE;
                    else                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE:   state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = DONE;
            WR_ISSUE:   state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // State, MAR and MDR registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

`ifdef MEM_FAULT_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = MEM_DEPTH[ADDR_W:0];

    logic fault_q, fault_d;

    assign out_of_range = ({1'b0, mar_d} >= DEPTH_LIM);

    // Fault flag latched on the IDLE decision, cleared when DONE retires.
    always_comb begin
        fault_d = fault_q;
        if (state_q == IDLE && (mem_write_req || mem_read_req)) fault_d = out_of_range;
        else if (state_q == DONE)                                fault_d = 1'b0;
    end

    // Fault flag register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    assign mem_fault = (state_q == DONE) && fault_q;
`else
    logic unused_depth;
    assign unused_depth = ^MEM_DEPTH;
    assign out_of_range = 1'b0;
    assign mem_fault    = 1'b0;
`endif

    assign ram_read     = (state_q == RD_ISSUE);
    assign ram_write    = (state_q == WR_ISSUE);
    assign mem_busy     = (state_q == RD_ISSUE) || (state_q == RD_CAPTURE) || (state_q == WR_ISSUE);
    assign mem_done     = (state_q == DONE);
    assign ram_addr     = mar_q;
    assign ram_wdata    = mdr_q;
    assign mdr_out_data = mdr_q;

endmodule
